// File: rtl/htif_mailbox_if.sv
// Register-port bundle between the MMIO crossbar (master) and the HTIF mailbox (slave).
// One outstanding request: a request handshake is followed by exactly one response handshake.
interface htif_mailbox_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/htif_mailbox.sv
// HTIF tohost/fromhost mailbox: register responder plus pass/exit capture for the harness.
// Optional watchdog enabled by defining HTIF_WATCHDOG_EN (adds the TIMEOUT parameter).
module htif_mailbox #(
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] TOHOST_OFF   = 12'h000,
  parameter logic [ADDR_W-1:0] FROMHOST_OFF = 12'h008
`ifdef HTIF_WATCHDOG_EN
  ,
  parameter int unsigned       TIMEOUT      = 50000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  htif_mailbox_if.slave       bus,
  output logic [63:0]         tohost,
  output logic                tohost_valid,
  input  logic                tohost_ack,
  input  logic                fromhost_valid,
  input  logic [63:0]         fromhost_data,
  output logic                pass,
  output logic [62:0]         exit_code,
  output logic                timeout
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic [63:0] tohost_r;
  logic        tohost_valid_r;
  logic [63:0] fromhost_r;
  logic        pass_r;
  logic [62:0] exit_code_r;
  logic [63:0] resp_rdata_r;
  logic        resp_err_r;

  logic        req_ready_s;
  logic        accept_s;
  logic        aligned_s;
  logic        hit_to_s;
  logic        hit_from_s;
  logic        ack_s;
  logic        to_busy_s;
  logic [63:0] to_base_s;
  logic [63:0] to_merge_s;
  logic [63:0] from_merge_s;
  logic        wr_to_s;
  logic        wr_from_s;
  logic        post_s;
  logic        rsp_err_s;
  logic [63:0] rsp_rdata_s;

  function automatic logic [63:0] merge_bytes(
    input logic [63:0] old_v,
    input logic [63:0] new_v,
    input logic [7:0]  strb
  );
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Decode, byte merge, commit qualifiers and the response to be registered.
  always_comb begin
    req_ready_s  = (state_r == ST_IDLE) && reset;
    accept_s     = bus.req_valid && req_ready_s;
    aligned_s    = (bus.req_addr[2:0] == 3'b000);
    hit_to_s     = aligned_s && (bus.req_addr[ADDR_W-1:3] == TOHOST_OFF[ADDR_W-1:3]);
    hit_from_s   = aligned_s && (bus.req_addr[ADDR_W-1:3] == FROMHOST_OFF[ADDR_W-1:3]);
    // An ack in the same cycle frees the register before the target write is judged.
    ack_s        = tohost_ack && tohost_valid_r;
    to_busy_s    = tohost_valid_r && !ack_s;
    to_base_s    = ack_s ? 64'd0 : tohost_r;
    to_merge_s   = merge_bytes(to_base_s, bus.req_wdata, bus.req_wstrb);
    from_merge_s = merge_bytes(fromhost_r, bus.req_wdata, bus.req_wstrb);
    wr_to_s      = accept_s && bus.req_write && hit_to_s && !to_busy_s;
    wr_from_s    = accept_s && bus.req_write && hit_from_s && !fromhost_valid;
    post_s       = wr_to_s && bus.req_wstrb[0] && (to_merge_s != 64'd0);

    rsp_err_s   = 1'b0;
    rsp_rdata_s = 64'd0;
    if (!hit_to_s && !hit_from_s) begin
      rsp_err_s = 1'b1;
    end else if (bus.req_write) begin
      rsp_err_s = hit_to_s && to_busy_s;
    end else if (hit_to_s) begin
      rsp_rdata_s = tohost_r;
    end else begin
      rsp_rdata_s = fromhost_r;
    end
  end

  // Bus FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Mailbox registers and the captured response.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tohost_r       <= 64'd0;
      tohost_valid_r <= 1'b0;
      fromhost_r     <= 64'd0;
      pass_r         <= 1'b0;
      exit_code_r    <= 63'd0;
      resp_rdata_r   <= 64'd0;
      resp_err_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        resp_rdata_r <= rsp_rdata_s;
        resp_err_r   <= rsp_err_s;
      end
      if (wr_to_s) begin
        tohost_r       <= to_merge_s;
        tohost_valid_r <= post_s;
      end else if (ack_s) begin
        tohost_r       <= 64'd0;
        tohost_valid_r <= 1'b0;
      end
      // Host load wins over a same-cycle target write to fromhost.
      if (fromhost_valid) begin
        fromhost_r <= fromhost_data;
      end else if (wr_from_s) begin
        fromhost_r <= from_merge_s;
      end
      if (post_s && to_merge_s[0] && !pass_r) begin
        pass_r      <= 1'b1;
        exit_code_r <= to_merge_s[63:1];
      end
    end
  end

`ifdef HTIF_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  logic [31:0] wd_count_r;
  logic        timeout_r;

  // Saturating idle counter, restarted by every tohost post; expiry is sticky.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_count_r <= 32'd0;
      timeout_r  <= 1'b0;
    end else begin
      if (post_s) begin
        wd_count_r <= 32'd0;
      end else if (wd_count_r != 32'hFFFF_FFFF) begin
        wd_count_r <= wd_count_r + 32'd1;
      end
      if (wd_count_r == WD_LAST) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = (state_r == ST_RESP);
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign tohost         = tohost_r;
  assign tohost_valid   = tohost_valid_r;
  assign pass           = pass_r;
  assign exit_code      = exit_code_r;

endmodule

// File: tb/tb_htif_mailbox.sv
// Directed and randomized checks of htif_mailbox against a transaction-level mailbox model.
module tb_htif_mailbox;

  logic        clock;
  logic        reset;
  logic [63:0] tohost;
  logic        tohost_valid;
  logic        tohost_ack;
  logic        fromhost_valid;
  logic [63:0] fromhost_data;
  logic        pass;
  logic [62:0] exit_code;
  logic        timeout;

  htif_mailbox_if #(.ADDR_W(12)) bus ();

`ifdef HTIF_WATCHDOG_EN
  htif_mailbox #(.ADDR_W(12), .TIMEOUT(100)) dut (
`else
  htif_mailbox #(.ADDR_W(12)) dut (
`endif
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .tohost         (tohost),
    .tohost_valid   (tohost_valid),
    .tohost_ack     (tohost_ack),
    .fromhost_valid (fromhost_valid),
    .fromhost_data  (fromhost_data),
    .pass           (pass),
    .exit_code      (exit_code),
    .timeout        (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_tohost;
  logic        m_valid;
  logic [63:0] m_fromhost;
  logic        m_pass;
  logic [62:0] m_exit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tohost   = 64'd0;
    m_valid    = 1'b0;
    m_fromhost = 64'd0;
    m_pass     = 1'b0;
    m_exit     = 63'd0;
  endtask

  task automatic model_req(input bit w, input logic [11:0] a, input logic [63:0] d,
                           input logic [7:0] s, input bit ack, input bit fv,
                           input logic [63:0] fd, output bit e_err, output logic [63:0] e_rdata);
    logic [63:0] mask;
    logic [63:0] merged;
    logic [63:0] old_to;
    logic [63:0] old_from;
    old_to   = m_tohost;
    old_from = m_fromhost;
    mask     = 64'd0;
    for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{s[b]}};
    e_err   = 1'b0;
    e_rdata = 64'd0;
    if (ack && m_valid) begin
      m_tohost = 64'd0;
      m_valid  = 1'b0;
    end
    if (a != 12'h000 && a != 12'h008) begin
      e_err = 1'b1;
    end else if (!w) begin
      e_rdata = (a == 12'h000) ? old_to : old_from;
    end else if (a == 12'h000) begin
      if (m_valid) begin
        e_err = 1'b1;
      end else begin
        merged   = (m_tohost & ~mask) | (d & mask);
        m_tohost = merged;
        if (s[0] && merged != 64'd0) begin
          m_valid = 1'b1;
          if (merged[0] && !m_pass) begin
            m_pass = 1'b1;
            m_exit = merged[63:1];
          end
        end
      end
    end else if (!fv) begin
      m_fromhost = (m_fromhost & ~mask) | (d & mask);
    end
    if (fv) m_fromhost = fd;
  endtask

  task automatic chk_mailbox(input string tag);
    chk({tag, ".tohost"}, tohost, m_tohost);
    chk({tag, ".tohost_valid"}, {63'd0, tohost_valid}, {63'd0, m_valid});
    chk({tag, ".pass"}, {63'd0, pass}, {63'd0, m_pass});
    chk({tag, ".exit_code"}, {1'b0, exit_code}, {1'b0, m_exit});
  endtask

  // Called #1 after a clock edge with the DUT idle; returns #1 after the response handshake edge.
  task automatic xact(input string tag, input bit w, input logic [11:0] a, input logic [63:0] d,
                      input logic [7:0] s, input bit ack, input bit fv, input logic [63:0] fd,
                      input int hold);
    bit          e_err;
    logic [63:0] e_rdata;
    chk({tag, ".req_ready_idle"}, {63'd0, bus.req_ready}, 64'd1);
    model_req(w, a, d, s, ack, fv, fd, e_err, e_rdata);
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_addr    = a;
    bus.req_wdata   = d;
    bus.req_wstrb   = s;
    bus.resp_ready  = (hold == 0);
    tohost_ack      = ack;
    fromhost_valid  = fv;
    fromhost_data   = fd;
    @(posedge clock); #1;
    bus.req_valid  = 1'b0;
    tohost_ack     = 1'b0;
    fromhost_valid = 1'b0;
    chk({tag, ".resp_valid"}, {63'd0, bus.resp_valid}, 64'd1);
    chk({tag, ".resp_err"}, {63'd0, bus.resp_err}, {63'd0, e_err});
    chk({tag, ".resp_rdata"}, bus.resp_rdata, e_rdata);
    chk({tag, ".req_ready_busy"}, {63'd0, bus.req_ready}, 64'd0);
    chk_mailbox(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk({tag, ".hold_valid"}, {63'd0, bus.resp_valid}, 64'd1);
      chk({tag, ".hold_rdata"}, bus.resp_rdata, e_rdata);
      chk({tag, ".hold_ready"}, {63'd0, bus.req_ready}, 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    chk({tag, ".resp_done"}, {63'd0, bus.resp_valid}, 64'd0);
    chk({tag, ".req_ready_back"}, {63'd0, bus.req_ready}, 64'd1);
  endtask

  task automatic idle_ack(input string tag);
    tohost_ack = 1'b1;
    if (m_valid) begin
      m_tohost = 64'd0;
      m_valid  = 1'b0;
    end
    @(posedge clock); #1;
    tohost_ack = 1'b0;
    chk_mailbox(tag);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tohost_ack     = 1'b0;
    fromhost_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    chk("rst.req_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("rst.resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst.resp_err", {63'd0, bus.resp_err}, 64'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst.timeout", {63'd0, timeout}, 64'd0);
    chk_mailbox("rst");
    reset = 1'b1;
    #1;
    chk("rst.req_ready_release", {63'd0, bus.req_ready}, 64'd1);
  endtask

  initial begin
    logic [11:0] addr_tab [6];
    logic [11:0] ra;
    logic [63:0] rd;
    int          sel;

    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 12'h000;
    bus.req_wdata  = 64'd0;
    bus.req_wstrb  = 8'h00;
    bus.resp_ready = 1'b1;
    tohost_ack     = 1'b0;
    fromhost_valid = 1'b0;
    fromhost_data  = 64'd0;
    model_reset();

    do_reset();

    // Exit-0 post: pass with exit_code 0
    xact("t1_post1", 1'b1, 12'h000, 64'h1, 8'hFF, 1'b0, 1'b0, 64'd0, 0);
    chk("t1.pass_const", {63'd0, pass}, 64'd1);
    chk("t1.exit_const", {1'b0, exit_code}, 64'd0);
    idle_ack("t1_ack");

    do_reset();

    // Write while posted is rejected
    xact("t2_post", 1'b1, 12'h000, 64'h0000_0000_8000_1000, 8'hFF, 1'b0, 1'b0, 64'd0, 0);
    xact("t2_busy", 1'b1, 12'h000, 64'h5, 8'hFF, 1'b0, 1'b0, 64'd0, 0);
    chk("t2.tohost_const", tohost, 64'h0000_0000_8000_1000);
    idle_ack("t2_ack");
    chk("t2.ack_tohost_const", tohost, 64'd0);
    idle_ack("t2_ack_ignored");

    // Response held under backpressure
    xact("t3_wr_from", 1'b1, 12'h008, 64'h1234, 8'hFF, 1'b0, 1'b0, 64'd0, 0);
    xact("t3_rd_hold", 1'b0, 12'h008, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 5);

    // Host load beats target write to fromhost
    xact("t4_from_race", 1'b1, 12'h008, 64'h0, 8'hFF, 1'b0, 1'b1, 64'hAB, 0);
    xact("t4_rd_from", 1'b0, 12'h008, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 0);
    // Same-cycle ack and new write: write commits and posts exit code 3
    xact("t4_post", 1'b1, 12'h000, 64'h0000_0000_8000_1000, 8'hFF, 1'b0, 1'b0, 64'd0, 0);
    xact("t4_ack_wr", 1'b1, 12'h000, 64'h7, 8'hFF, 1'b1, 1'b0, 64'd0, 0);
    chk("t4.tohost_const", tohost, 64'h7);
    chk("t4.exit_const", {1'b0, exit_code}, 64'd3);
    xact("t4_rd_to", 1'b0, 12'h000, 64'd0, 8'h00, 1'b1, 1'b0, 64'd0, 0);

    // Decode errors
    xact("t5_rd_004", 1'b0, 12'h004, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 0);
    xact("t5_rd_010", 1'b0, 12'h010, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 0);
    xact("t5_wr_00c", 1'b1, 12'h00C, 64'hFFFF, 8'hFF, 1'b0, 1'b0, 64'd0, 0);
    xact("t5_partial", 1'b1, 12'h000, 64'h1122_3344_5566_7700, 8'hF0, 1'b0, 1'b0, 64'd0, 0);

    // Randomized traffic
    do_reset();
    addr_tab[0] = 12'h000; addr_tab[1] = 12'h000; addr_tab[2] = 12'h008;
    addr_tab[3] = 12'h008; addr_tab[4] = 12'h004; addr_tab[5] = 12'h010;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 5);
      ra  = addr_tab[sel];
      if ($urandom_range(0, 3) == 0) begin
        rd = {60'd0, 4'($urandom_range(0, 15))};
      end else begin
        rd = {$urandom, $urandom};
      end
      if ($urandom_range(0, 5) == 0) begin
        idle_ack("rnd_ack");
      end else begin
        xact("rnd", 1'($urandom_range(0, 1)), ra, rd, 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), {$urandom, $urandom},
             $urandom_range(0, 2));
      end
    end

    // Reset while a response is pending
    xact("t6_post", 1'b1, 12'h000, 64'h9, 8'hFF, 1'b0, 1'b0, 64'd0, 0);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 12'h000;
    bus.resp_ready = 1'b0;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    chk("t6.pending", {63'd0, bus.resp_valid}, 64'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    model_reset();
    chk("t6.resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("t6.resp_rdata", bus.resp_rdata, 64'd0);
    chk("t6.resp_err", {63'd0, bus.resp_err}, 64'd0);
    chk("t6.req_ready", {63'd0, bus.req_ready}, 64'd0);
    chk_mailbox("t6");
    reset          = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    chk("t6.no_stale_resp", {63'd0, bus.resp_valid}, 64'd0);
    chk("t6.req_ready_back", {63'd0, bus.req_ready}, 64'd1);

`ifdef HTIF_WATCHDOG_EN
    do_reset();
    repeat (99) @(posedge clock);
    #1;
    chk("wd.before", {63'd0, timeout}, 64'd0);
    @(posedge clock); #1;
    chk("wd.expire", {63'd0, timeout}, 64'd1);
    do_reset();
    repeat (49) @(posedge clock);
    #1;
    xact("wd_post", 1'b1, 12'h000, 64'h2, 8'hFF, 1'b0, 1'b0, 64'd0, 0);
    repeat (98) @(posedge clock);
    #1;
    chk("wd.delayed_before", {63'd0, timeout}, 64'd0);
    @(posedge clock); #1;
    chk("wd.delayed_expire", {63'd0, timeout}, 64'd1);
`else
    repeat (120) @(posedge clock);
    #1;
    chk("wd.disabled", {63'd0, timeout}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
